// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: parses a framed little-endian stream,
// writes 32-bit words from address 0 and releases the core on a valid checksum.
//
// state  | meaning
// -------+-----------------------------------------------------------
// HDR0   | waiting for the low byte of the word count
// HDR1   | waiting for the high byte of the word count
// DATA   | assembling words and writing them to instruction memory
// CSUM   | waiting for the checksum byte
// DONE   | frame loaded and checksum matched, core released
// ERR    | overflow or checksum mismatch, core held in reset
module imem_loader #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              core_rst_n,
   output logic              load_done,
   output logic              load_error
);

   typedef enum logic [2:0] {
      S_HDR0,
      S_HDR1,
      S_DATA,
      S_CSUM,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [15:0]     DEPTH16 = 16'(DEPTH);
   localparam logic [ADDR_W:0] WONE    = {{ADDR_W{1'b0}}, 1'b1};

   state_t            state, state_nxt;
   logic              accept;
   logic [7:0]        cnt_lo;
   logic [15:0]       cnt_hdr;
   logic [ADDR_W:0]   cnt;
   logic [1:0]        byte_cnt;
   logic [ADDR_W:0]   widx;
   logic [ADDR_W:0]   widx_inc;
   logic [23:0]       word_asm;
   logic [7:0]        xsum;

   assign accept   = in_valid && in_ready;
   assign cnt_hdr  = {in_data, cnt_lo};
   assign widx_inc = widx + WONE;

   always_comb begin
      state_nxt = state;
      case (state)
         S_HDR0: if (accept) state_nxt = S_HDR1;
         S_HDR1: begin
            if (accept) begin
               if (cnt_hdr > DEPTH16)    state_nxt = S_ERR;
               else if (cnt_hdr == 16'd0) state_nxt = S_CSUM;
               else                       state_nxt = S_DATA;
            end
         end
         S_DATA: begin
            if (accept && byte_cnt == 2'd3 && widx_inc == cnt) state_nxt = S_CSUM;
         end
         S_CSUM: if (accept) state_nxt = (in_data == xsum) ? S_DONE : S_ERR;
         S_DONE, S_ERR: if (start) state_nxt = S_HDR0;
         default: state_nxt = S_HDR0;
      endcase
   end

   // in_ready is registered from the next state so it never depends on in_valid
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_HDR0;
         in_ready <= 1'b0;
      end else begin
         state    <= state_nxt;
         in_ready <= (state_nxt == S_HDR0) || (state_nxt == S_HDR1) ||
                     (state_nxt == S_DATA) || (state_nxt == S_CSUM);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_lo    <= '0;
         cnt       <= '0;
         byte_cnt  <= '0;
         widx      <= '0;
         word_asm  <= '0;
         xsum      <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_HDR0: begin
               if (accept) begin
                  cnt_lo <= in_data;
                  xsum   <= xsum ^ in_data;
               end
            end
            S_HDR1: begin
               if (accept) begin
                  cnt      <= cnt_hdr[ADDR_W:0];
                  xsum     <= xsum ^ in_data;
                  byte_cnt <= '0;
               end
            end
            S_DATA: begin
               if (accept) begin
                  xsum     <= xsum ^ in_data;
                  word_asm <= {in_data, word_asm[23:8]};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     mem_we    <= 1'b1;
                     mem_wdata <= {in_data, word_asm};
                     mem_addr  <= widx[ADDR_W-1:0];
                     widx      <= widx_inc;
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (start) begin
                  xsum <= '0;
                  widx <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   assign load_done  = (state == S_DONE);
   assign load_error = (state == S_ERR);
   assign core_rst_n = (state == S_DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: table vectors, hand-written corner cases
// and random frames checked against a frame-level reference model.
module tb_imem_loader;

   typedef logic [7:0]  bq_t[$];
   typedef logic [31:0] wq_t[$];

   typedef struct {
      int          addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   typedef struct {
      string       name;
      int          len;
      logic [95:0] b;
      int          nwr;
      logic [31:0] w0;
      logic [31:0] w1;
      bit          done;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_ready;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst_n;
   logic        load_done;
   logic        load_error;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   wr_t wq[$];
   int  acc[$];

   imem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .core_rst_n(core_rst_n), .load_done(load_done), .load_error(load_error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // acc holds the edge at which each byte is accepted; wq the edge after which mem_we was seen
   always @(negedge clk) begin
      if (rst_n && in_valid && in_ready) acc.push_back(cyc + 1);
      if (mem_we) wq.push_back('{int'(mem_addr), mem_wdata, cyc});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input int stall, output bit ok);
      ok = 1'b1;
      while (stall > 0 && $urandom_range(0, 99) < stall) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      for (int g = 0; !in_ready; g++) begin
         if (g >= 40) begin
            ok = 1'b0;
            in_valid = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bq_t bytes, input int stall);
      bit ok;
      foreach (bytes[i]) begin
         send_byte(bytes[i], stall, ok);
         if (!ok) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: byte %0d never accepted, expected in_ready=1", i);
            return;
         end
      end
   endtask

   // Reference model: frame bytes from a word list, with an optionally corrupted checksum
   function automatic bq_t build_frame(input wq_t words, input int n, input bit bad);
      bq_t f;
      logic [7:0] x;
      f.push_back(8'(n));
      f.push_back(8'(n >> 8));
      if (n <= 1024) begin
         foreach (words[k])
            for (int j = 0; j < 4; j++) f.push_back(8'(words[k] >> (8 * j)));
         x = 8'h00;
         foreach (f[i]) x = x ^ f[i];
         f.push_back(bad ? (x ^ 8'(1 + $urandom_range(0, 254))) : x);
      end
      return f;
   endfunction

   task automatic check_frame(input string name, input wq_t exp, input bit exp_done);
      repeat (4) @(posedge clk);
      #1;
      chk({name, "_nwrites"}, 32'(wq.size()), 32'(exp.size()));
      foreach (exp[j]) begin
         if (j < wq.size()) begin
            chk({name, "_addr"}, 32'(wq[j].addr), 32'(j));
            chk({name, "_data"}, wq[j].data, exp[j]);
            if (4 * j + 5 < acc.size())
               chk({name, "_wlat"}, 32'(wq[j].cyc), 32'(acc[4 * j + 5]));
         end
      end
      if (exp.size() > 0) begin
         chk({name, "_hold_addr"}, 32'(mem_addr), 32'(exp.size() - 1));
         chk({name, "_hold_data"}, mem_wdata, exp[exp.size() - 1]);
      end
      chk({name, "_done"}, 32'(load_done), 32'(exp_done));
      chk({name, "_error"}, 32'(load_error), 32'(!exp_done));
      chk({name, "_core_rst_n"}, 32'(core_rst_n), 32'(exp_done));
      chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
   endtask

   task automatic rearm(input string name);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk({name, "_rearm_done"}, 32'(load_done), 32'd0);
      chk({name, "_rearm_error"}, 32'(load_error), 32'd0);
      chk({name, "_rearm_core_rst_n"}, 32'(core_rst_n), 32'd0);
      chk({name, "_rearm_in_ready"}, 32'(in_ready), 32'd1);
      wq.delete();
      acc.delete();
   endtask

   task automatic check_reset_values(input string name);
      chk({name, "_in_ready"}, 32'(in_ready), 32'd0);
      chk({name, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({name, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({name, "_mem_wdata"}, mem_wdata, 32'd0);
      chk({name, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
      chk({name, "_done"}, 32'(load_done), 32'd0);
      chk({name, "_error"}, 32'(load_error), 32'd0);
   endtask

   initial begin
      vec_t vecs[6];
      bq_t  f;
      wq_t  w;
      wq_t  two;
      int   n;
      bit   bad;

      vecs[0] = '{"two_word",  11, 96'h02_00_33_00_00_00_13_03_50_00_71_00, 2, 32'h00000033, 32'h00500313, 1'b1};
      vecs[1] = '{"bad_csum",  11, 96'h02_00_33_00_00_00_13_03_50_00_70_00, 2, 32'h00000033, 32'h00500313, 1'b0};
      vecs[2] = '{"overflow",   2, 96'h01_04_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0};
      vecs[3] = '{"empty",      3, 96'h00_00_00_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b1};
      vecs[4] = '{"one_word",   7, 96'h01_00_EF_BE_AD_DE_23_00_00_00_00_00, 1, 32'hDEADBEEF, 32'h0, 1'b1};
      vecs[5] = '{"empty_bad",  3, 96'h00_00_5A_00_00_00_00_00_00_00_00_00, 0, 32'h0, 32'h0, 1'b0};
      two = '{32'h00000033, 32'h00500313};

      #2 rst_n = 1'b0;
      #1 check_reset_values("reset");
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      #1 chk("reset_ready_before_edge", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("reset_ready_after_edge", 32'(in_ready), 32'd1);
      wq.delete();
      acc.delete();

      // Table vectors, first back-to-back then with random stalls
      for (int pass = 0; pass < 2; pass++) begin
         foreach (vecs[v]) begin
            f.delete();
            w.delete();
            for (int i = 0; i < vecs[v].len; i++) f.push_back(vecs[v].b[95 - 8 * i -: 8]);
            if (vecs[v].nwr > 0) w.push_back(vecs[v].w0);
            if (vecs[v].nwr > 1) w.push_back(vecs[v].w1);
            send_frame(f, pass * 40);
            check_frame(vecs[v].name, w, vecs[v].done);
            rearm(vecs[v].name);
         end
      end

      // start while mid-frame must be ignored
      f = build_frame(two, 2, 1'b0);
      send_frame(f[0:3], 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("start_ignored_ready", 32'(in_ready), 32'd1);
      send_frame(f[4:10], 0);
      check_frame("start_ignored", two, 1'b1);
      rearm("start_ignored");

      // Reset after six bytes: the write triggered by byte six is pending on this edge
      send_frame(f[0:5], 0);
      rst_n = 1'b0;
      #1 check_reset_values("midreset");
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("midreset_ready", 32'(in_ready), 32'd1);
      wq.delete();
      acc.delete();
      send_frame(f, 0);
      check_frame("after_midreset", two, 1'b1);
      rearm("after_midreset");

      // Random frames against the reference model
      for (int r = 0; r < 24; r++) begin
         w.delete();
         if ($urandom_range(0, 5) == 0) n = $urandom_range(1025, 65535);
         else n = $urandom_range(0, 6);
         if (n <= 1024) for (int k = 0; k < n; k++) w.push_back($urandom);
         bad = ($urandom_range(0, 3) == 0);
         f = build_frame(w, n, bad);
         send_frame(f, $urandom_range(0, 1) * 50);
         check_frame("random", w, (n <= 1024) && !bad);
         rearm("random");
      end

      // Full depth, word k = k
      w.delete();
      for (int k = 0; k < 1024; k++) w.push_back(32'(k));
      f = build_frame(w, 1024, 1'b0);
      send_frame(f, 0);
      check_frame("full_depth", w, 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation time exceeded, expected completion");
      $fatal(1, "timeout");
   end

endmodule
